// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types for hazard_ctrl_sb and its load scoreboard
// Scoreboard entries store register selects up to SB_WSEL_W bits wide.
package hazard_pkg;

    localparam int SB_WSEL_W = 8;

    typedef enum logic [2:0] {
        PC_NEXT = 3'b000,
        PC_J    = 3'b001,
        PC_BEQ  = 3'b010,
        PC_JR   = 3'b011,
        PC_BNE  = 3'b110
    } pcsrc_t;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MEMWAIT = 2'b01
    } hu_state_t;

    typedef struct packed {
        logic                 valid;
        logic [SB_WSEL_W-1:0] wsel;
    } sb_entry_t;

endpackage

// File: rtl/load_scoreboard.sv
// rtl/load_scoreboard.sv - shadow shift register of in-flight load destinations
// Entry k tracks the load currently k stages past EX; hold freezes, squash/bubble inject empties.
module load_scoreboard
    import hazard_pkg::*;
#(
    parameter int REGW     = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            i_hold,
    input  logic            i_squash,
    input  logic            i_bubble,
    input  logic            i_push_valid,
    input  logic [REGW-1:0] i_push_wsel,
    input  logic [REGW-1:0] i_rs,
    input  logic [REGW-1:0] i_rt,
    output logic            o_match
);

    sb_entry_t r_sb   [LOAD_LAT];
    sb_entry_t w_next [LOAD_LAT];
    sb_entry_t w_push;

    always_comb begin
        w_push.valid = i_push_valid & (i_push_wsel != '0);
        w_push.wsel  = SB_WSEL_W'(i_push_wsel);
    end

    // A redirect squashes the load leaving EX as well as the instruction entering it.
    always_comb begin
        w_next[0] = (i_squash | i_bubble) ? '0 : w_push;
        for (int k = 1; k < LOAD_LAT; k++) begin
            w_next[k] = (i_squash && k == 1) ? '0 : r_sb[k-1];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int k = 0; k < LOAD_LAT; k++) begin
                r_sb[k] <= '0;
            end
        end else if (!i_hold) begin
            r_sb <= w_next;
        end
    end

    always_comb begin
        o_match = 1'b0;
        for (int k = 0; k < LOAD_LAT; k++) begin
            if (r_sb[k].valid && r_sb[k].wsel != '0 &&
                (r_sb[k].wsel == SB_WSEL_W'(i_rs) || r_sb[k].wsel == SB_WSEL_W'(i_rt))) begin
                o_match = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl_sb.sv
// rtl/hazard_ctrl_sb.sv - pipeline hazard control: memory freeze, redirect flush, load-use stall
// Define HAZARD_PERF_EN to add saturating stall_cycles / flush_count counters.
module hazard_ctrl_sb
    import hazard_pkg::*;
#(
    parameter int REGW     = 5,
    parameter int LOAD_LAT = 1,
    parameter int PCSRCW   = 3
`ifdef HAZARD_PERF_EN
    ,
    parameter int CNTW     = 16
`endif
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [REGW-1:0]   ifid_rs,
    input  logic [REGW-1:0]   ifid_rt,
    input  logic              id_load,
    input  logic [REGW-1:0]   id_wsel,
    input  logic              exmem_dREN,
    input  logic              exmem_dWEN,
    input  logic              dhit,
    input  logic [PCSRCW-1:0] exmem_PCSrc,
    input  logic              exmem_ZeroFlag,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic              memwb_flush,
    output logic [1:0]        hu_state
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNTW-1:0]   stall_cycles,
    output logic [CNTW-1:0]   flush_count
`endif
);

    logic      w_req;
    logic      w_freeze;
    logic      w_taken;
    logic      w_redirect;
    logic      w_match;
    logic      w_stall;
    hu_state_t r_state;
    hu_state_t w_state_next;

    assign w_req    = exmem_dREN | exmem_dWEN;
    assign w_freeze = w_req & ~dhit;
    assign w_taken  = (exmem_PCSrc == PCSRCW'(PC_J)) |
                      (exmem_PCSrc == PCSRCW'(PC_JR)) |
                      ((exmem_PCSrc == PCSRCW'(PC_BEQ)) & exmem_ZeroFlag) |
                      ((exmem_PCSrc == PCSRCW'(PC_BNE)) & ~exmem_ZeroFlag);

    // A branch caught by a freeze stays in MEM and redirects on the release cycle.
    assign w_redirect = ~w_freeze & w_taken;
    assign w_stall    = ~w_freeze & ~w_taken & w_match;

    load_scoreboard #(
        .REGW     (REGW),
        .LOAD_LAT (LOAD_LAT)
    ) u_sb (
        .CLK          (CLK),
        .nRST         (nRST),
        .i_hold       (w_freeze),
        .i_squash     (w_redirect),
        .i_bubble     (w_stall),
        .i_push_valid (id_load),
        .i_push_wsel  (id_wsel),
        .i_rs         (ifid_rs),
        .i_rt         (ifid_rt),
        .o_match      (w_match)
    );

    always_comb begin
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (w_freeze) begin
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (w_redirect) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (w_stall) begin
            ifid_en     = 1'b0;
            idex_flush  = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:     if (w_freeze) w_state_next = MEMWAIT;
            MEMWAIT: if (dhit || !w_req) w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

    assign hu_state = r_state;

`ifdef HAZARD_PERF_EN
    logic [CNTW-1:0] r_stall_cycles;
    logic [CNTW-1:0] r_flush_count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_stall && r_stall_cycles != '1) begin
                r_stall_cycles <= r_stall_cycles + CNTW'(1);
            end
            if (w_redirect && r_flush_count != '1) begin
                r_flush_count <= r_flush_count + CNTW'(1);
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// tb/tb_hazard_ctrl_sb.sv - directed and randomized checks of hazard_ctrl_sb at LOAD_LAT 1 and 2
// Honours HAZARD_PERF_EN when defined.
module tb_hazard_ctrl_sb;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic [4:0] ifid_rs = '0;
    logic [4:0] ifid_rt = '0;
    logic       id_load = 1'b0;
    logic [4:0] id_wsel = '0;
    logic       exmem_dREN = 1'b0;
    logic       exmem_dWEN = 1'b0;
    logic       dhit = 1'b0;
    logic [2:0] exmem_PCSrc = '0;
    logic       exmem_ZeroFlag = 1'b0;

    logic       ifid_en [2];
    logic       idex_en [2];
    logic       exmem_en [2];
    logic       ifid_flush [2];
    logic       idex_flush [2];
    logic       exmem_flush [2];
    logic       memwb_flush [2];
    logic [1:0] hu_state [2];
`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cycles [2];
    logic [15:0] flush_count [2];
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    hazard_ctrl_sb #(.REGW(5), .LOAD_LAT(1), .PCSRCW(3)) u_lat1 (
        .CLK(CLK), .nRST(nRST), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .id_load(id_load),
        .id_wsel(id_wsel), .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN), .dhit(dhit),
        .exmem_PCSrc(exmem_PCSrc), .exmem_ZeroFlag(exmem_ZeroFlag),
        .ifid_en(ifid_en[0]), .idex_en(idex_en[0]), .exmem_en(exmem_en[0]),
        .ifid_flush(ifid_flush[0]), .idex_flush(idex_flush[0]), .exmem_flush(exmem_flush[0]),
        .memwb_flush(memwb_flush[0]), .hu_state(hu_state[0])
`ifdef HAZARD_PERF_EN
        , .stall_cycles(stall_cycles[0]), .flush_count(flush_count[0])
`endif
    );

    hazard_ctrl_sb #(.REGW(5), .LOAD_LAT(2), .PCSRCW(3)) u_lat2 (
        .CLK(CLK), .nRST(nRST), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .id_load(id_load),
        .id_wsel(id_wsel), .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN), .dhit(dhit),
        .exmem_PCSrc(exmem_PCSrc), .exmem_ZeroFlag(exmem_ZeroFlag),
        .ifid_en(ifid_en[1]), .idex_en(idex_en[1]), .exmem_en(exmem_en[1]),
        .ifid_flush(ifid_flush[1]), .idex_flush(idex_flush[1]), .exmem_flush(exmem_flush[1]),
        .memwb_flush(memwb_flush[1]), .hu_state(hu_state[1])
`ifdef HAZARD_PERF_EN
        , .stall_cycles(stall_cycles[1]), .flush_count(flush_count[1])
`endif
    );

    // Reference: per latency, a list of pending load destinations with cycles-until-forwardable.
    int mdest [2][8];
    int mttl  [2][8];
    int mcnt  [2];
    bit m_prev_frz;
    int m_stalls [2];
    int m_flushes [2];

    function automatic bit m_freeze();
        return (exmem_dREN || exmem_dWEN) && !dhit;
    endfunction

    function automatic bit m_taken();
        case (exmem_PCSrc)
            3'd1, 3'd3: return 1'b1;
            3'd2:       return exmem_ZeroFlag;
            3'd6:       return !exmem_ZeroFlag;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic bit m_hazard(int d);
        for (int i = 0; i < mcnt[d]; i++) begin
            if (mdest[d][i] != 0 && (mdest[d][i] == int'(ifid_rs) || mdest[d][i] == int'(ifid_rt)))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [8:0] m_exp(int d);
        bit fr;
        bit rd;
        bit st;
        fr = m_freeze();
        rd = !fr && m_taken();
        st = !fr && !rd && m_hazard(d);
        return {!(fr || st), !fr, !fr, rd, rd || st, rd, fr, 1'b0, m_prev_frz};
    endfunction

    function automatic logic [8:0] obs(int d);
        return {ifid_en[d], idex_en[d], exmem_en[d], ifid_flush[d], idex_flush[d],
                exmem_flush[d], memwb_flush[d], hu_state[d]};
    endfunction

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            mcnt[d] = 0;
            m_stalls[d] = 0;
            m_flushes[d] = 0;
        end
        m_prev_frz = 1'b0;
    endtask

    task automatic m_advance();
        bit fr;
        bit rd;
        fr = m_freeze();
        rd = !fr && m_taken();
        for (int d = 0; d < 2; d++) begin
            int lat;
            int n;
            int nd [8];
            int nt [8];
            bit st;
            lat = d + 1;
            n = 0;
            st = !fr && !rd && m_hazard(d);
            if (!fr) begin
                if (rd) m_flushes[d]++;
                else if (st) m_stalls[d]++;
                for (int i = 0; i < mcnt[d]; i++) begin
                    // the load just leaving EX is squashed by a redirect
                    if ((!rd || mttl[d][i] < lat) && mttl[d][i] > 1) begin
                        nd[n] = mdest[d][i];
                        nt[n] = mttl[d][i] - 1;
                        n++;
                    end
                end
                if (!rd && !st && id_load && id_wsel != 0) begin
                    nd[n] = int'(id_wsel);
                    nt[n] = lat;
                    n++;
                end
                for (int i = 0; i < n; i++) begin
                    mdest[d][i] = nd[i];
                    mttl[d][i] = nt[i];
                end
                mcnt[d] = n;
            end
        end
        m_prev_frz = fr;
    endtask

    task automatic tick();
        @(posedge CLK);
        if (nRST) m_advance();
        #1;
    endtask

    task automatic drive(input int rs, input int rt, input bit ld, input int ws,
                         input bit rd, input bit wr, input bit hit, input int pc, input bit z);
        ifid_rs = 5'(rs);
        ifid_rt = 5'(rt);
        id_load = ld;
        id_wsel = 5'(ws);
        exmem_dREN = rd;
        exmem_dWEN = wr;
        dhit = hit;
        exmem_PCSrc = 3'(pc);
        exmem_ZeroFlag = z;
    endtask

    task automatic idle(int n);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        m_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        @(negedge CLK);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs(d) !== 9'b1110000_00) begin
                errors++;
                $display("FAIL reset_out lat=%0d got %b exp %b", d + 1, obs(d), 9'b1110000_00);
            end
`ifdef HAZARD_PERF_EN
            checks++;
            if (stall_cycles[d] !== 16'd0 || flush_count[d] !== 16'd0) begin
                errors++;
                $display("FAIL reset_perf lat=%0d got %0d/%0d exp 0/0", d + 1, stall_cycles[d], flush_count[d]);
            end
`endif
        end
        tick();
        nRST = 1'b1;
    endtask

    task automatic test_load_use();
        int sc [2];
        // load r3 then add r4,r3,r1 held in ID
        sc[0] = 0;
        sc[1] = 0;
        drive(0, 0, 1, 3, 0, 0, 0, 0, 0);
        @(negedge CLK);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs(d) !== m_exp(d)) begin
                errors++;
                $display("FAIL load_use_push lat=%0d got %b exp %b", d + 1, obs(d), m_exp(d));
            end
        end
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(3, 1, 0, 4, 0, 0, 0, 0, 0);
            @(negedge CLK);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs(d) !== m_exp(d)) begin
                    errors++;
                    $display("FAIL load_use lat=%0d cyc=%0d got %b exp %b", d + 1, c, obs(d), m_exp(d));
                end
                if (!ifid_en[d] && idex_flush[d]) sc[d]++;
            end
            tick();
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (sc[d] !== d + 1) begin
                errors++;
                $display("FAIL load_use_count lat=%0d got %0d exp %0d", d + 1, sc[d], d + 1);
            end
        end
        idle(3);
        // load r3, independent op, then the dependent add
        sc[0] = 0;
        sc[1] = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 0) drive(0, 0, 1, 3, 0, 0, 0, 0, 0);
            else if (c == 1) drive(7, 8, 0, 9, 0, 0, 0, 0, 0);
            else drive(3, 1, 0, 4, 0, 0, 0, 0, 0);
            @(negedge CLK);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs(d) !== m_exp(d)) begin
                    errors++;
                    $display("FAIL load_gap lat=%0d cyc=%0d got %b exp %b", d + 1, c, obs(d), m_exp(d));
                end
                if (!ifid_en[d]) sc[d]++;
            end
            tick();
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (sc[d] !== d) begin
                errors++;
                $display("FAIL load_gap_count lat=%0d got %0d exp %0d", d + 1, sc[d], d);
            end
        end
        idle(3);
    endtask

    task automatic test_r0();
        for (int c = 0; c < 3; c++) begin
            if (c == 0) drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
            else drive(0, 0, 0, 5, 0, 0, 0, 0, 0);
            @(negedge CLK);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs(d) !== 9'b1110000_00 || obs(d) !== m_exp(d)) begin
                    errors++;
                    $display("FAIL r0_no_stall lat=%0d cyc=%0d got %b exp %b", d + 1, c, obs(d), 9'b1110000_00);
                end
            end
            tick();
        end
        idle(3);
    endtask

    task automatic test_freeze();
        logic [8:0] want;
        drive(0, 0, 1, 6, 0, 0, 0, 0, 0);
        tick();
        // four miss cycles then the hit cycle; ID reads r6 throughout
        for (int c = 1; c <= 6; c++) begin
            if (c <= 4) drive(6, 0, 1, 7, 1, 0, 0, 0, 0);
            else if (c == 5) drive(6, 0, 0, 0, 1, 0, 1, 0, 0);
            else drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            if (c == 1) want = 9'b0000001_00;
            else if (c <= 4) want = 9'b0000001_01;
            else if (c == 5) want = 9'b0110100_01;
            else want = 9'b1110000_00;
            @(negedge CLK);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs(d) !== want || obs(d) !== m_exp(d)) begin
                    errors++;
                    $display("FAIL freeze lat=%0d cyc=%0d got %b exp %b", d + 1, c, obs(d), want);
                end
            end
            tick();
        end
        idle(3);
    endtask

    task automatic test_redirect();
        logic [8:0] want;
        drive(0, 0, 1, 5, 0, 0, 0, 0, 0);
        tick();
        for (int c = 1; c <= 6; c++) begin
            case (c)
                1: begin drive(5, 0, 1, 8, 0, 0, 0, 6, 0); want = 9'b1111110_00; end
                2: begin drive(8, 5, 0, 0, 0, 0, 0, 0, 0); want = 9'b1110000_00; end
                3: begin drive(0, 0, 0, 0, 1, 0, 0, 1, 0); want = 9'b0000001_00; end
                4: begin drive(0, 0, 0, 0, 1, 0, 0, 1, 0); want = 9'b0000001_01; end
                5: begin drive(0, 0, 0, 0, 1, 0, 1, 1, 0); want = 9'b1111110_01; end
                default: begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0); want = 9'b1110000_00; end
            endcase
            @(negedge CLK);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs(d) !== want || obs(d) !== m_exp(d)) begin
                    errors++;
                    $display("FAIL redirect lat=%0d cyc=%0d got %b exp %b", d + 1, c, obs(d), want);
                end
            end
            tick();
        end
        for (int pz = 0; pz < 16; pz++) begin
            drive(0, 0, 0, 0, 0, 0, 0, pz >> 1, pz[0]);
            @(negedge CLK);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs(d) !== m_exp(d)) begin
                    errors++;
                    $display("FAIL pcsrc_decode lat=%0d pc=%0d z=%0d got %b exp %b", d + 1, pz >> 1, pz & 1, obs(d), m_exp(d));
                end
            end
            tick();
        end
        idle(3);
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 600; c++) begin
            r = $urandom_range(0, 9);
            drive($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), r == 0, r == 1, ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : 0, 1'($urandom_range(0, 1)));
            @(negedge CLK);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs(d) !== m_exp(d)) begin
                    errors++;
                    $display("FAIL random lat=%0d cyc=%0d got %b exp %b", d + 1, c, obs(d), m_exp(d));
                end
            end
            tick();
        end
`ifdef HAZARD_PERF_EN
        @(negedge CLK);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (int'(stall_cycles[d]) !== m_stalls[d] || int'(flush_count[d]) !== m_flushes[d]) begin
                errors++;
                $display("FAIL random_perf lat=%0d got %0d/%0d exp %0d/%0d", d + 1,
                         stall_cycles[d], flush_count[d], m_stalls[d], m_flushes[d]);
            end
        end
`endif
        idle(3);
    endtask

    task automatic test_mid_reset();
        nRST = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        m_reset();
        tick();
        nRST = 1'b1;
        // 3 load-use pairs, 2 jumps, then a fresh load-use left pending
        for (int c = 0; c < 10; c++) begin
            if (c < 6) begin
                if (c % 2 == 0) drive(0, 0, 1, 2, 0, 0, 0, 0, 0);
                else drive(2, 0, 0, 0, 0, 0, 0, 0, 0);
            end else if (c < 8) drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
            else if (c == 8) drive(0, 0, 1, 2, 0, 0, 0, 0, 0);
            else drive(2, 2, 0, 0, 0, 0, 0, 0, 0);
            @(negedge CLK);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs(d) !== m_exp(d)) begin
                    errors++;
                    $display("FAIL pre_reset lat=%0d cyc=%0d got %b exp %b", d + 1, c, obs(d), m_exp(d));
                end
            end
            if (c < 9) tick();
        end
        checks++;
        if (obs(0) !== 9'b0110100_00) begin
            errors++;
            $display("FAIL pending_stall lat=1 got %b exp %b", obs(0), 9'b0110100_00);
        end
`ifdef HAZARD_PERF_EN
        checks++;
        if (stall_cycles[0] !== 16'd3 || flush_count[0] !== 16'd2) begin
            errors++;
            $display("FAIL perf_counts lat=1 got %0d/%0d exp 3/2", stall_cycles[0], flush_count[0]);
        end
        checks++;
        if (int'(stall_cycles[1]) !== m_stalls[1] || int'(flush_count[1]) !== m_flushes[1]) begin
            errors++;
            $display("FAIL perf_counts lat=2 got %0d/%0d exp %0d/%0d", stall_cycles[1], flush_count[1], m_stalls[1], m_flushes[1]);
        end
`endif
        #1;
        nRST = 1'b0;
        #1;
        m_reset();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs(d) !== 9'b1110000_00) begin
                errors++;
                $display("FAIL mid_reset_out lat=%0d got %b exp %b", d + 1, obs(d), 9'b1110000_00);
            end
`ifdef HAZARD_PERF_EN
            checks++;
            if (stall_cycles[d] !== 16'd0 || flush_count[d] !== 16'd0) begin
                errors++;
                $display("FAIL mid_reset_perf lat=%0d got %0d/%0d exp 0/0", d + 1, stall_cycles[d], flush_count[d]);
            end
`endif
        end
        tick();
        nRST = 1'b1;
        @(negedge CLK);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs(d) !== 9'b1110000_00 || obs(d) !== m_exp(d)) begin
                errors++;
                $display("FAIL post_reset lat=%0d got %b exp %b", d + 1, obs(d), 9'b1110000_00);
            end
        end
        tick();
        idle(2);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_r0();
        test_freeze();
        test_redirect();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_sb.md
Name: hazard_ctrl_sb

Overview:
Parametrised successor to the pipeline hazard unit for the 5-stage MIPS core. It adds an internal load scoreboard, a shadow shift register of in-flight load destinations, which detects load-use hazards for a configurable load-to-use latency. It also adds an explicit memory-wait FSM and a fixed priority among memory freeze, branch/jump flush and load-use stall. It sits beside the datapath and drives all pipeline-latch enables and flushes.

Parameters:
REGW, 5, register-select width (2^REGW architectural registers; register 0 never hazards)
LOAD_LAT, 1, scoreboard depth: stages past ID in which a load result is not yet forwardable (1..3)
PCSRCW, 3, width of the PC-source select
CNTW, 16, width of the perf counters (optional feature only)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
ifid_rs  in  REGW  source register 1 of the instruction in ID
ifid_rt  in  REGW  source register 2 of the instruction in ID
id_load  in  1  instruction in ID is a load
id_wsel  in  REGW  destination of the instruction in ID
exmem_dREN  in  1  data read pending in MEM
exmem_dWEN  in  1  data write pending in MEM
dhit  in  1  data memory completes this cycle
exmem_PCSrc  in  PCSRCW  PC-source select of the instruction in MEM
exmem_ZeroFlag  in  1  ALU zero flag of the instruction in MEM
ifid_en, idex_en, exmem_en  out  1 each  latch enables
ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  latch flushes
hu_state  out  2  FSM state, for debug
stall_cycles  out  CNTW  (HAZARD_PERF_EN only) load-use stall cycle count
flush_count  out  CNTW  (HAZARD_PERF_EN only) taken-redirect count

Behaviour:
- Control outputs are combinational from the inputs and registered state.
- Defaults: all enables 1, all flushes 0.
- Reset: shadow cleared, FSM = RUN, counters = 0. Control outputs then take their defaults unless the inputs dictate otherwise.
- Shadow: LOAD_LAT entries, each {valid, wsel}.
  - Entry 0 is the load in EX; entry k is the load in EX+k.
- Priority: freeze > redirect > load-use stall > normal.
- freeze = (exmem_dREN | exmem_dWEN) & !dhit.
  - Drives ifid_en = idex_en = exmem_en = 0 and memwb_flush = 1.
  - The shadow holds its contents.
  - redirect and stall outputs are suppressed for the cycle.
- redirect = PCSrc J (001) | JR (011) | (BEQ (010) & Zero) | (BNE (110) & !Zero).
  - Applies only when not frozen.
  - Drives ifid_flush = idex_flush = exmem_flush = 1.
  - Shadow update: entry0 <- 0 and entry1 <- 0 (the load in EX was squashed); entry k <- old k-1 for k >= 2.
- stall: applies when not frozen and not redirecting.
  - Condition: any valid entry with wsel != 0 and wsel == ifid_rs or ifid_rt.
  - Drives ifid_en = 0 and idex_flush = 1 (bubble).
  - Shadow shifts with entry0 <- 0.
  - A LOAD_LAT = 1 load-use costs exactly 1 stall cycle.
- Normal: shadow shifts; entry0 <- {id_load & (id_wsel != 0), id_wsel}.
- FSM hu_state:
  - RUN (00): on freeze, go to MEMWAIT (01).
  - MEMWAIT (01): on dhit, or when no request is pending, go to RUN.
  - 10 and 11 are illegal and recover to RUN.
  - Freeze is combinational in both states, so the dhit cycle is already un-frozen.
- Simultaneous redirect and freeze: the redirect is deferred. The branch stays in MEM while frozen and takes effect on the release cycle.
- Mid-operation reset clears the shadow, so a pending stall releases immediately.

Optional Feature:
HAZARD_PERF_EN
- Defined: stall_cycles increments every load-use stall cycle; flush_count increments every redirect cycle. Both saturate at all-ones and reset to 0.
- Undefined: both ports and their counters are absent. Control behaviour is identical either way.

Decomposition:
- Package hazard_pkg holds:
  - pcsrc_t enum: PC_NEXT = 000, PC_J = 001, PC_BEQ = 010, PC_JR = 011, PC_BNE = 110.
  - hu_state_t enum: RUN, MEMWAIT.
  - sb_entry_t struct: {valid, wsel}.
- One sub-module, load_scoreboard: holds the shadow shift register, takes push/bubble/squash/hold controls, and outputs the match for rs/rt.

Test Plan:
- LOAD_LAT = 1. Load r3 in ID, then `add r4, r3, r1` in ID next cycle -> ifid_en = 0 and idex_flush = 1 for exactly 1 cycle, then normal.
- LOAD_LAT = 2. Same pair -> 2 consecutive stall cycles. With one independent instruction between them -> 1 stall cycle.
- Load to r0 followed by a read of r0 -> no stall.
- exmem_dREN = 1, dhit = 0 for 4 cycles, then dhit = 1 -> 4 cycles of all enables 0 and memwb_flush = 1. hu_state = 01 from cycle 2 through the dhit cycle, then 00. Shadow unchanged.
- exmem_PCSrc = 110 with Zero = 0 while a load to r5 sits in EX and ID reads r5 -> three flushes asserted, no stall. The next ID read of r5 also does not stall.
- Assert nRST low mid-stall -> shadow cleared, FSM RUN, counters 0. With HAZARD_PERF_EN: 3 stalls and 2 redirects before the reset give stall_cycles = 3 and flush_count = 2.
